// File: rtl/pattern_6_8_resp_misr.sv
// Response compactor for the merged pattern_6_8 stage: skips a settle interval after start,
// folds valid 11-bit responses into a MISR over a programmable window, then compares to a golden signature.
module pattern_6_8_resp_misr #(
   parameter int                SIG_W  = 16,
   parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
   parameter logic [SIG_W-1:0]  SEED   = 16'h0000,
   parameter int                SETTLE = 4,
   parameter int                WIN_W  = 8
) (
   input  logic             blif_clk_net_0,
   input  logic             blif_reset_net_0,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic [10:0]      resp_in,
   input  logic             resp_valid,
   input  logic [SIG_W-1:0] expected_sig,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [WIN_W-1:0] sample_count
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SKIP    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_settle;
   logic [WIN_W-1:0]   r_win;
   logic [WIN_W-1:0]   r_count;
   logic [SIG_W-1:0]   r_sig;
   logic               r_pass;
   logic               w_accept;
   logic               w_absorb;
   logic               w_last;
   logic [WIN_W-1:0]   w_count_inc;
   logic [SIG_W-1:0]   w_sig_next;

   assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_absorb    = (r_state == S_CAPTURE) && resp_valid;
   assign w_count_inc = r_count + WIN_W'(1);
   assign w_last      = (w_count_inc == r_win);
   assign w_sig_next  = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(resp_in);

   always_ff @(posedge blif_clk_net_0) begin
      if (blif_reset_net_0) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next = (SETTLE > 0) ? S_SKIP : S_CAPTURE;
            end
         end
         S_SKIP: begin
            if (r_settle <= CNT_W'(1)) begin
               w_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (w_absorb && w_last) begin
               w_next = S_DONE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A latched window of zero is stored as one so the compare above never has to special-case it.
   always_ff @(posedge blif_clk_net_0) begin
      if (blif_reset_net_0) begin
         r_sig    <= SEED;
         r_count  <= '0;
         r_pass   <= 1'b0;
         r_settle <= '0;
         r_win    <= '0;
      end else begin
         if (w_accept) begin
            r_sig    <= SEED;
            r_count  <= '0;
            r_pass   <= 1'b0;
            r_settle <= CNT_W'(SETTLE);
            r_win    <= (win_len == '0) ? WIN_W'(1) : win_len;
         end
         if (r_state == S_SKIP) begin
            r_settle <= r_settle - CNT_W'(1);
         end
         if (w_absorb) begin
            r_sig   <= w_sig_next;
            r_count <= w_count_inc;
            if (w_last) begin
               r_pass <= (w_sig_next == expected_sig);
            end
         end
      end
   end

   assign busy         = (r_state == S_SKIP) || (r_state == S_CAPTURE);
   assign done         = (r_state == S_DONE);
   assign pass         = r_pass;
   assign signature    = r_sig;
   assign sample_count = r_count;

endmodule

// File: tb/tb_pattern_6_8_resp_misr.sv
// Randomized bench for pattern_6_8_resp_misr: each run is predicted cycle by cycle from the
// settle/window rules, with the signature computed by polynomial reduction in a reference function.
module tb_pattern_6_8_resp_misr;

   localparam int          SETTLE = 4;
   localparam logic [15:0] POLY   = 16'h1021;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start_b;
   logic [7:0]  win_len;
   logic [10:0] resp_in;
   logic        resp_valid;
   logic [15:0] expected_sig;

   logic        busy, done, pass;
   logic [15:0] signature;
   logic [7:0]  sample_count;
   logic        b_busy, b_done, b_pass;
   logic [15:0] b_signature;
   logic [7:0]  b_sample_count;

   int n_checks = 0;
   int n_fail   = 0;

   pattern_6_8_resp_misr #(
      .SIG_W(16), .POLY(POLY), .SEED(16'h0000), .SETTLE(SETTLE), .WIN_W(8)
   ) dut (
      .blif_clk_net_0(clk), .blif_reset_net_0(rst), .start(start), .win_len(win_len),
      .resp_in(resp_in), .resp_valid(resp_valid), .expected_sig(expected_sig),
      .busy(busy), .done(done), .pass(pass), .signature(signature), .sample_count(sample_count)
   );

   pattern_6_8_resp_misr #(
      .SIG_W(16), .POLY(POLY), .SEED(16'h8000), .SETTLE(0), .WIN_W(8)
   ) dut_fb (
      .blif_clk_net_0(clk), .blif_reset_net_0(rst), .start(start_b), .win_len(win_len),
      .resp_in(resp_in), .resp_valid(resp_valid), .expected_sig(expected_sig),
      .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_signature),
      .sample_count(b_sample_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Multiply by x modulo the generator polynomial, then add the response word.
   function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [10:0] d);
      logic [16:0] t;
      t = {s, 1'b0};
      if (t[16]) t = t ^ {1'b1, POLY};
      return t[15:0] ^ {5'd0, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: random valid at pct%; mode 1: valid=1, data=0x001; mode 2: valid pattern 1,0,0,1,0,1
   task automatic run(input logic [7:0] wl, input int mode, input int pct, input bit want_pass,
                      input bit poke, output int done_cyc, output logic [15:0] fin_sig);
      int          eff, cnt, cyc;
      bit          fin, absorb;
      logic [15:0] sig;
      logic [5:0]  gap;
      gap = 6'b101001;
      eff = (wl == 8'd0) ? 1 : int'(wl);
      cnt = 0; cyc = 0; fin = 0; sig = 16'h0000;
      start = 1'b1; win_len = wl; resp_valid = 1'b1; resp_in = 11'($urandom);
      tick();
      start = 1'b0;
      check_eq("start_busy", busy, 1);
      check_eq("start_done", done, 0);
      check_eq("start_pass", pass, 0);
      check_eq("start_sig", signature, 16'h0000);
      check_eq("start_count", sample_count, 0);
      while (!fin && cyc < 3000) begin
         cyc++;
         start   = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         win_len = 8'($urandom);
         resp_in = (mode == 1) ? 11'h001 : 11'($urandom);
         case (mode)
            1:       resp_valid = 1'b1;
            2:       resp_valid = (cyc <= SETTLE) ? 1'b1 : gap[(cyc - SETTLE - 1) % 6];
            default: resp_valid = ($urandom_range(0, 99) < pct);
         endcase
         absorb       = (cyc > SETTLE) && resp_valid;
         expected_sig = 16'($urandom);
         if (absorb) begin
            sig = misr_ref(sig, resp_in);
            cnt++;
            if (cnt == eff) begin
               fin = 1;
               expected_sig = want_pass ? sig : (sig ^ 16'h0007);
            end
         end
         tick();
         check_eq("run_sig", signature, sig);
         check_eq("run_count", sample_count, cnt);
         check_eq("run_busy", busy, !fin);
         check_eq("run_done", done, fin);
         if (fin) check_eq("run_pass", pass, want_pass);
      end
      start = 1'b0;
      resp_valid = 1'b0;
      if (!fin) check_eq("run_timeout", 0, 1);
      done_cyc = cyc;
      fin_sig  = sig;
   endtask

   initial begin
      int          dc;
      logic [15:0] fs;
      rst = 1'b1; start = 1'b0; start_b = 1'b0; win_len = 8'd0;
      resp_in = 11'd0; resp_valid = 1'b0; expected_sig = 16'd0;
      tick(); tick();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pass", pass, 0);
      check_eq("rst_sig", signature, 16'h0000);
      check_eq("rst_count", sample_count, 0);
      check_eq("rst_fb_sig", b_signature, 16'h8000);
      rst = 1'b0;
      tick();

      // Settle skip with continuous valid data 0x001.
      run(8'd2, 1, 100, 1'b1, 1'b0, dc, fs);
      check_eq("settle_sig", signature, 16'h0003);
      check_eq("settle_done_edge", dc, SETTLE + 2);
      check_eq("settle_pass", pass, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check_eq("rst_from_done_pass", pass, 0);
      check_eq("rst_from_done_done", done, 0);
      check_eq("rst_from_done_sig", signature, 16'h0000);

      run(8'd2, 1, 100, 1'b0, 1'b0, dc, fs);
      check_eq("settle_fail_sig", signature, 16'h0003);
      check_eq("settle_fail_pass", pass, 0);

      // Gapped valid, then back-to-back restarts from DONE.
      run(8'd3, 2, 0, 1'b1, 1'b0, dc, fs);
      check_eq("gap_count", sample_count, 3);
      check_eq("gap_cycles", dc, SETTLE + 6);

      // start pulses during SKIP/CAPTURE must be ignored.
      run(8'd20, 0, 50, 1'b1, 1'b1, dc, fs);
      check_eq("poke_count", sample_count, 20);
      run(8'd9, 0, 70, 1'b0, 1'b1, dc, fs);

      run(8'd0, 0, 60, 1'b1, 1'b0, dc, fs);
      check_eq("win0_count", sample_count, 1);
      run(8'd255, 0, 85, 1'b1, 1'b0, dc, fs);
      check_eq("win255_count", sample_count, 255);
      check_eq("win255_done", done, 1);

      for (int i = 0; i < 4; i++) begin
         run(8'($urandom_range(1, 40)), 0, int'($urandom_range(20, 100)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dc, fs);
      end

      // Reset held two cycles in the middle of CAPTURE.
      start = 1'b1; win_len = 8'd50; tick();
      start = 1'b0; resp_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         resp_in = 11'($urandom);
         tick();
      end
      check_eq("mid_count", sample_count, 3);
      rst = 1'b1; tick(); tick();
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_pass", pass, 0);
      check_eq("mid_rst_sig", signature, 16'h0000);
      check_eq("mid_rst_count", sample_count, 0);
      rst = 1'b0; resp_valid = 1'b0;
      tick();

      // Feedback tap: SEED=0x8000, no settle, one sample of 0x7FF.
      start_b = 1'b1; win_len = 8'd1; tick();
      start_b = 1'b0;
      check_eq("fb_busy", b_busy, 1);
      resp_valid = 1'b1; resp_in = 11'h7FF; expected_sig = 16'h17DE;
      tick();
      resp_valid = 1'b0;
      check_eq("fb_sig", b_signature, 16'h17DE);
      check_eq("fb_done", b_done, 1);
      check_eq("fb_pass", b_pass, 1);
      check_eq("fb_count", b_sample_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
